// File: rtl/uart_byte_receiver_pkg.sv
// Shared line-rate defaults and frame-timing helpers for the GPZDA receive path.
// The sentence and field receivers import the same CLOCK_HZ/BAUD defaults.
package uart_byte_receiver_pkg;

    localparam int unsigned DEF_CLOCK_HZ = 100_000_000;
    localparam int unsigned DEF_BAUD     = 9600;
    localparam int unsigned DEF_B        = 8;

    function automatic int unsigned calc_div(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_receiver_rx_synchronizer.sv
// Two-flop synchroniser for the raw rx line plus a one-cycle history flop.
// All flops reset high so an idle line never looks like a start edge.
module rx_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    // [0] metastable stage, [1] rx_s, [2] rx_p history
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], rx};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 byte receiver: start-edge detect, mid-bit sampling, stop-bit check.
// Emits a one-cycle load with the byte, or a one-cycle frame_error.
module uart_byte_receiver
    import uart_byte_receiver_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = DEF_CLOCK_HZ,
    parameter int unsigned BAUD     = DEF_BAUD,
    parameter int unsigned B        = DEF_B
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx,
    output logic [B-1:0] data,
    output logic         load,
    output logic         frame_error,
    output logic         busy
);

    localparam int unsigned DIV  = calc_div(CLOCK_HZ, BAUD);
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned TW   = $clog2(DIV);
    localparam int unsigned IW   = (B > 1) ? $clog2(B) : 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(B - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_byte_receiver: CLOCK_HZ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    logic rx_s;
    logic fall;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [B-1:0]  shreg_q, shreg_d;
    logic [B-1:0]  data_q, data_d;
    logic          load_q, load_d;
    logic          ferr_q, ferr_d;

    rx_synchronizer u_sync (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        load_d  = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                idx_d   = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the start bit at its centre to reject glitches
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shreg_d = {rx_s, shreg_q[B-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving here at mid-stop leaves half a bit to catch the next start
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shreg_q;
                        load_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            load_q  <= load_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data        = data_q;
    assign load        = load_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver at CLOCK_HZ=16, BAUD=1 (16 clocks per bit).
// Expected events come from sampling the recorded line at the nominal bit centres.
module tb_uart_byte_receiver;

    localparam int DIV  = 16;
    localparam int HALF = 8;
    localparam int LAT  = 2 + HALF + 9 * DIV + 1;
    localparam int HMAX = 8192;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       load;
    logic       frame_error;
    logic       busy;

    uart_byte_receiver #(
        .CLOCK_HZ (16),
        .BAUD     (1),
        .B        (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .load        (load),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
    } ev_t;

    logic line_hist [0:HMAX-1];
    ev_t  got_ld[$];
    ev_t  exp_ld[$];
    int   got_fe[$];
    int   exp_fe[$];
    logic [7:0] prev_data;
    logic rst_prev = 1'b1;

    always @(negedge clock) begin
        if (cyc < HMAX) line_hist[cyc] = rx;
        if (load === 1'b1) got_ld.push_back('{cyc, data});
        if (frame_error === 1'b1) got_fe.push_back(cyc);
        checks++;
        assert (!(load === 1'b1 && frame_error === 1'b1)) else begin
            errors++;
            $error("FAIL excl cyc %0d load %b frame_error %b expected not both",
                   cyc, load, frame_error);
        end
        if (!rst_prev && !reset) begin
            checks++;
            assert (load === 1'b1 || data === prev_data) else begin
                errors++;
                $error("FAIL data_hold cyc %0d got %h expected %h", cyc, data, prev_data);
            end
        end
        prev_data = data;
        rst_prev  = reset;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic tick_to(input int t);
        do @(negedge clock); while (cyc < t);
    endtask

    // Caller must be at a drive point (#1 after a posedge)
    task automatic send_frame(input logic [7:0] b, input int per,
                              input logic stop, input int tail_low,
                              output int n);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        n = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (per) @(posedge clock);
            #1;
        end
        if (tail_low > 0) begin
            rx = 1'b0;
            repeat (tail_low) @(posedge clock);
            #1;
        end
        rx = 1'b1;
    endtask

    // Line falls at cycle e: sample the recorded line at each bit centre
    function automatic void predict(input int e);
        logic [7:0] d;
        if (line_hist[e + HALF] !== 1'b0) return;
        for (int k = 1; k <= 8; k++) d[k-1] = line_hist[e + HALF + k * DIV];
        if (line_hist[e + HALF + 9 * DIV] === 1'b1) exp_ld.push_back('{e + LAT, d});
        else exp_fe.push_back(e + LAT);
    endfunction

    task automatic drain(input string tag);
        int nl;
        int nf;
        checks++;
        assert (got_ld.size() == exp_ld.size()) else begin
            errors++;
            $error("FAIL %s load_count got %0d expected %0d", tag, got_ld.size(), exp_ld.size());
        end
        nl = (got_ld.size() < exp_ld.size()) ? got_ld.size() : exp_ld.size();
        for (int i = 0; i < nl; i++) begin
            checks++;
            assert (got_ld[i].c == exp_ld[i].c && got_ld[i].d === exp_ld[i].d) else begin
                errors++;
                $error("FAIL %s load%0d got cyc %0d data %h expected cyc %0d data %h",
                       tag, i, got_ld[i].c, got_ld[i].d, exp_ld[i].c, exp_ld[i].d);
            end
        end
        checks++;
        assert (got_fe.size() == exp_fe.size()) else begin
            errors++;
            $error("FAIL %s ferr_count got %0d expected %0d", tag, got_fe.size(), exp_fe.size());
        end
        nf = (got_fe.size() < exp_fe.size()) ? got_fe.size() : exp_fe.size();
        for (int i = 0; i < nf; i++) begin
            checks++;
            assert (got_fe[i] == exp_fe[i]) else begin
                errors++;
                $error("FAIL %s ferr%0d got cyc %0d expected cyc %0d",
                       tag, i, got_fe[i], exp_fe[i]);
            end
        end
        got_ld.delete();
        exp_ld.delete();
        got_fe.delete();
        exp_fe.delete();
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    initial begin
        int n, n2;
        logic [7:0] b;
        int per, gap;
        logic stop;

        // Reset held while rx toggles
        reset = 1'b1;
        idle(2);
        for (int i = 0; i < 6; i++) begin
            rx = ~rx;
            idle(1);
        end
        rx = 1'b1;
        idle(3);
        @(negedge clock);
        chk_bit("rst_load", load, 1'b0);
        chk_bit("rst_ferr", frame_error, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        checks++;
        assert (data === 8'h00) else begin
            errors++;
            $error("FAIL rst_data got %h expected %h", data, 8'h00);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(5);
        chk_bit("idle_busy", busy, 1'b0);

        // Single '$'
        send_frame(8'h24, 16, 1'b1, 0, n);
        idle(20);
        predict(n);
        drain("dollar");

        // 'G','P' back to back
        send_frame(8'h47, 16, 1'b1, 0, n);
        send_frame(8'h50, 16, 1'b1, 0, n2);
        idle(20);
        predict(n);
        predict(n2);
        drain("gp");

        // Three-cycle glitch
        n = cyc;
        rx = 1'b0;
        idle(2);
        @(negedge clock);
        chk_bit("glitch_busy_t0", busy, 1'b0);
        @(posedge clock);
        #1;
        rx = 1'b1;
        @(negedge clock);
        chk_bit("glitch_busy_t1", busy, 1'b1);
        tick_to(n + 10);
        chk_bit("glitch_busy_t8", busy, 1'b1);
        tick_to(n + 11);
        chk_bit("glitch_busy_t9", busy, 1'b0);
        idle(20);
        predict(n);
        drain("glitch");

        // Bad stop bit, line then held low
        send_frame(8'h5A, 16, 1'b0, 100, n);
        chk_bit("hold_busy", busy, 1'b0);
        idle(10);
        predict(n);
        drain("ferr");
        checks++;
        assert (data === 8'h50) else begin
            errors++;
            $error("FAIL ferr_data got %h expected %h", data, 8'h50);
        end
        send_frame(8'h2C, 16, 1'b1, 0, n);
        idle(20);
        predict(n);
        drain("after_ferr");

        // Reset pulse during data bit 4 of 0x41
        fork
            send_frame(8'h41, 16, 1'b1, 0, n);
            begin
                idle(85);
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
                @(negedge clock);
                chk_bit("rst_mid_busy", busy, 1'b0);
            end
        join
        idle(100);
        // Released synchroniser sees the still-low line as a fresh edge
        predict(n + 86);
        drain("rst_mid");
        send_frame(8'h2C, 16, 1'b1, 0, n);
        idle(20);
        predict(n);
        drain("after_rst");

        // Off-rate senders
        send_frame(8'h5A, 15, 1'b1, 0, n);
        idle(20);
        predict(n);
        send_frame(8'h5A, 17, 1'b1, 0, n);
        idle(20);
        predict(n);
        drain("offrate");

        // Random bytes, rates and gaps
        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom);
            per  = $urandom_range(15, 17);
            gap  = $urandom_range(5, 30);
            stop = (per != 16) || ($urandom_range(0, 3) != 0);
            send_frame(b, per, stop, 0, n);
            idle(gap);
            predict(n);
        end
        idle(200);
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
